// File: rtl/triangle_burst_controller_if.sv
// -----------------------------------------------------------------------------
// triangle_burst_controller_if
//   Command channel into the triangle burst controller. A command is a
//   {rate divider, period count} pair moved with a valid/ready handshake.
//
//   cmd_valid    master -> slave   command present
//   cmd_ready    slave  -> master  controller can take a command
//   cmd_div      master -> slave   strobe every cmd_div+1 clocks
//   cmd_periods  master -> slave   periods to run, 0 = free-run
// -----------------------------------------------------------------------------
interface triangle_burst_controller_if #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 16
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [DIV_W-1:0] cmd_div;
  logic [CNT_W-1:0] cmd_periods;

  modport master (
    output cmd_valid,
    output cmd_div,
    output cmd_periods,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_div,
    input  cmd_periods,
    output cmd_ready
  );

endinterface

// File: rtl/triangle_burst_controller.sv
// -----------------------------------------------------------------------------
// triangle_burst_controller
//   Runs a triangle_generator (width N) for a programmed number of complete
//   0 -> max -> 0 periods. A command sets the strobe rate and the period
//   count; the controller resets the generator, strobes its enable at the
//   programmed rate, counts finished periods and pulses done at the end.
//
//   clk           in   clock
//   rst           in   asynchronous reset, active-high
//   cmd           if   command channel (slave side)
//   pause         in   freeze prescaler and step count, no strobes
//   abort         in   end burst now, reset generator, no done
//   gen_rst       out  generator reset
//   gen_ena       out  generator enable strobe
//   busy          out  burst in progress (INIT or RUN)
//   done          out  one-cycle pulse after the last period completes
//   periods_done  out  completed periods of the current/last burst
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   CLEAR | generator held in reset for one cycle, then go idle
//   IDLE  | waiting for a command, cmd_ready high
//   INIT  | command latched, generator held in reset for one cycle
//   RUN   | strobing gen_ena at the programmed rate, counting periods
//   DONE  | programmed period count reached, done pulse for one cycle
// -----------------------------------------------------------------------------
module triangle_burst_controller #(
  parameter int N     = 8,
  parameter int DIV_W = 16,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  triangle_burst_controller_if.slave   cmd,
  input  logic                         pause,
  input  logic                         abort,
  output logic                         gen_rst,
  output logic                         gen_ena,
  output logic                         busy,
  output logic                         done,
  output logic [CNT_W-1:0]             periods_done
);

  // One generator period is 2^(N+1)-2 strobes: up 2^N-1 steps, down 2^N-1.
  localparam int              STEP_W    = N + 1;
  localparam int              PERIOD    = (1 << (N + 1)) - 2;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(PERIOD - 1);

  typedef enum logic [2:0] {
    CLEAR = 3'd0,
    IDLE  = 3'd1,
    INIT  = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [DIV_W-1:0]  div_r;
  logic [CNT_W-1:0]  per_r;
  logic [DIV_W-1:0]  presc;
  logic [STEP_W-1:0] step;

  logic              accept;
  logic              strobe;
  logic              period_end;
  logic              last_period;
  logic [CNT_W-1:0]  periods_inc;

  // ---------------------------------------------------------------------------
  // Strobe and period-completion decode
  // ---------------------------------------------------------------------------
  // pause/abort gate the strobe combinationally so a strobe is suppressed in
  // the very cycle they are raised.
  assign strobe      = (state == RUN) && (presc == div_r) && !pause && !abort;
  assign period_end  = strobe && (step == STEP_LAST);
  assign periods_inc = periods_done + CNT_W'(1);
  // per_r == 0 means free-run, so no period count can ever end the burst.
  assign last_period = (per_r != '0) && (periods_inc == per_r);
  assign accept      = (state == IDLE) && cmd.cmd_valid;

  assign gen_ena     = strobe;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and Moore outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt     = state;
    gen_rst       = 1'b0;
    cmd.cmd_ready = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;

    case (state)
      CLEAR: begin
        gen_rst   = 1'b1;
        state_nxt = IDLE;
      end

      IDLE: begin
        cmd.cmd_ready = 1'b1;
        if (accept) begin
          state_nxt = INIT;
        end
      end

      INIT: begin
        gen_rst = 1'b1;
        busy    = 1'b1;
        if (abort) begin
          state_nxt = CLEAR;
        end else begin
          state_nxt = RUN;
        end
      end

      RUN: begin
        busy = 1'b1;
        // abort wins over the final strobe; strobe is already masked by abort.
        if (abort) begin
          state_nxt = CLEAR;
        end else if (period_end && last_period) begin
          state_nxt = DONE;
        end
      end

      DONE: begin
        done = 1'b1;
        if (abort) begin
          state_nxt = CLEAR;
        end else begin
          state_nxt = IDLE;
        end
      end

      default: begin
        gen_rst   = 1'b1;
        state_nxt = CLEAR;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Command latch, prescaler, step and period counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_r        <= '0;
      per_r        <= '0;
      presc        <= '0;
      step         <= '0;
      periods_done <= '0;
    end else begin
      if (accept) begin
        div_r        <= cmd.cmd_div;
        per_r        <= cmd.cmd_periods;
        presc        <= '0;
        step         <= '0;
        periods_done <= '0;
      end else if (state == RUN) begin
        if (!pause) begin
          if (presc == div_r) begin
            presc <= '0;
          end else begin
            presc <= presc + DIV_W'(1);
          end
        end

        if (strobe) begin
          if (period_end) begin
            step         <= '0;
            periods_done <= periods_inc;
          end else begin
            step <= step + STEP_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_triangle_burst_controller.sv
// -----------------------------------------------------------------------------
// tb_triangle_burst_controller
//   Directed table of bursts, randomized bursts against a cycle-level
//   reference model, and hand-written reset / handshake / abort sequences.
// -----------------------------------------------------------------------------
module tb_triangle_burst_controller;

  localparam int PERIOD = 510;

  logic        clk;
  logic        rst;
  logic        pause;
  logic        abort;
  logic        gen_rst;
  logic        gen_ena;
  logic        busy;
  logic        done;
  logic [15:0] periods_done;

  int n_cmp = 0;
  int n_err = 0;

  triangle_burst_controller_if #(.DIV_W(16), .CNT_W(16)) cmd_bus ();

  triangle_burst_controller #(.N(8), .DIV_W(16), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd          (cmd_bus),
    .pause        (pause),
    .abort        (abort),
    .gen_rst      (gen_rst),
    .gen_ena      (gen_ena),
    .busy         (busy),
    .done         (done),
    .periods_done (periods_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference triangle generator driven by the controller outputs.
  int gen_val;
  bit gen_up;
  always @(posedge clk or posedge rst) begin
    if (rst || gen_rst) begin
      gen_val <= 0;
      gen_up  <= 1'b1;
    end else if (gen_ena) begin
      if (gen_up) begin
        gen_val <= gen_val + 1;
        if (gen_val + 1 == 255) gen_up <= 1'b0;
      end else begin
        gen_val <= gen_val - 1;
        if (gen_val - 1 == 0) gen_up <= 1'b1;
      end
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  // Runs one burst from IDLE and checks every cycle against the model:
  // strobes fall on every (div+1)-th unpaused RUN cycle, each 510 strobes
  // is one period, the burst ends after periods*510 strobes or on abort.
  task automatic run_burst(input int div, input int periods, input int pause_at,
                           input int pause_len, input int abort_at,
                           output int d_str, output int d_done_k, output int d_pd);
    int e, strobes, phase, pause_left, errs, s_total;
    bit p, would, a, exp_ena, fin, ok;
    logic [20:0] act_v, exp_v;
    logic [15:0] exp_pd;

    d_str = 0; d_done_k = 0; d_pd = 0; errs = 0; fin = 1'b0; ok = 1'b0;
    for (int w = 0; w < 20; w++) begin
      @(negedge clk);
      if (cmd_bus.cmd_ready) begin ok = 1'b1; break; end
    end
    check("idle_wait", ok, 1);
    if (!ok) begin pulse_reset(); return; end

    cmd_bus.cmd_valid   = 1'b1;
    cmd_bus.cmd_div     = 16'(div);
    cmd_bus.cmd_periods = 16'(periods);
    @(posedge clk);
    #1;
    cmd_bus.cmd_valid   = 1'b0;
    cmd_bus.cmd_div     = 16'($urandom);
    cmd_bus.cmd_periods = 16'($urandom);
    @(negedge clk);
    check("init_cycle", {gen_ena, busy, gen_rst, done, cmd_bus.cmd_ready}, 5'b01100);

    e = 0; strobes = 0; phase = 0; pause_left = pause_len; s_total = PERIOD * periods;
    for (int k = 1; k < 20000 && !fin; k++) begin
      p = 1'b0; would = 1'b0; a = 1'b0;
      @(posedge clk);
      #1;
      if (phase == 0) begin
        p = (pause_left > 0) && (strobes >= pause_at);
        if (p) pause_left--;
        would = !p && (((e + 1) % (div + 1)) == 0);
        a = (abort_at != 0) && would && (strobes + 1 == abort_at);
      end
      pause = p;
      abort = a;
      @(negedge clk);
      exp_pd  = 16'(strobes / PERIOD);
      exp_ena = would && !a;
      case (phase)
        0:       exp_v = {exp_ena, 4'b1000, exp_pd};
        1:       exp_v = {5'b00010, exp_pd};
        2:       exp_v = {5'b00100, exp_pd};
        default: exp_v = {5'b00001, exp_pd};
      endcase
      act_v = {gen_ena, busy, gen_rst, done, cmd_bus.cmd_ready, periods_done};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_err++; errs++;
        $display("FAIL cycle k=%0d phase=%0d {ena,busy,rst,done,rdy,pd}: got %h expected %h",
                 k, phase, act_v, exp_v);
      end
      if (gen_ena) d_str++;
      if (done && d_done_k == 0) d_done_k = k;
      if (phase == 1) check("gen_at_zero", gen_val, 0);
      case (phase)
        0: begin
          if (!p) e++;
          if (exp_ena) strobes++;
          if (a) phase = 2;
          else if (exp_ena && periods != 0 && strobes == s_total) phase = 1;
        end
        1, 2:    phase = 3;
        default: fin = 1'b1;
      endcase
      if (errs > 5) break;
    end
    pause = 1'b0;
    abort = 1'b0;
    d_pd  = int'(periods_done);
    check("burst_finished", fin, 1);
    if (!fin) pulse_reset();
  endtask

  typedef struct {
    int div;
    int periods;
    int pause_at;
    int pause_len;
    int abort_at;
    int exp_strobes;
    int exp_done_k;
    int exp_pd;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int d_str, d_k, d_pd, bad_ready, dv, pr, pa, pl, ab;

    rst = 1'b1; pause = 1'b0; abort = 1'b0;
    cmd_bus.cmd_valid = 1'b0; cmd_bus.cmd_div = '0; cmd_bus.cmd_periods = '0;

    //             div per p_at p_len abort  strobes done_k pd
    tbl[0] = '{0, 1,   0,   0,    0,    510,   511,  1};
    tbl[1] = '{3, 2,   0,   0,    0,   1020,  4081,  2};
    tbl[2] = '{1, 1, 200,  10,    0,    510,  1031,  1};
    tbl[3] = '{2, 1,   0,   0,  100,     99,     0,  0};
    tbl[4] = '{0, 0,   0,   0, 1531,   1530,     0,  3};
    tbl[5] = '{0, 1,   0,   0,  510,    509,     0,  0};
    tbl[6] = '{2, 1,   0,   0,    0,    510,  1531,  1};
    tbl[7] = '{0, 1, 509,   3,    0,    510,   514,  1};

    #2;
    check("reset_outputs", {gen_rst, gen_ena, busy, done, cmd_bus.cmd_ready}, 5'b10000);
    check("reset_pd", periods_done, 0);
    #10 rst = 1'b0;
    #1 check("clear_after_reset", {gen_rst, cmd_bus.cmd_ready}, 2'b10);
    @(negedge clk);
    check("idle_after_clear", {gen_rst, busy, cmd_bus.cmd_ready}, 3'b001);

    for (int i = 0; i < 8; i++) begin
      run_burst(tbl[i].div, tbl[i].periods, tbl[i].pause_at, tbl[i].pause_len,
                tbl[i].abort_at, d_str, d_k, d_pd);
      check($sformatf("tbl%0d_strobes", i), d_str, tbl[i].exp_strobes);
      check($sformatf("tbl%0d_done_k", i), d_k, tbl[i].exp_done_k);
      check($sformatf("tbl%0d_pd", i), d_pd, tbl[i].exp_pd);
    end

    for (int i = 0; i < 6; i++) begin
      dv = $urandom_range(0, 3);
      pr = $urandom_range(0, 2);
      pa = $urandom_range(0, 500);
      pl = $urandom_range(0, 12);
      ab = 0;
      if (pr == 0 || $urandom_range(0, 2) == 0)
        ab = $urandom_range(1, PERIOD * ((pr == 0) ? 2 : pr));
      run_burst(dv, pr, pa, pl, ab, d_str, d_k, d_pd);
    end

    // Async reset between clock edges in the middle of a burst.
    @(negedge clk);
    cmd_bus.cmd_valid = 1'b1; cmd_bus.cmd_div = 16'd0; cmd_bus.cmd_periods = 16'd1;
    @(posedge clk);
    #1 cmd_bus.cmd_valid = 1'b0;
    repeat (50) @(posedge clk);
    @(negedge clk);
    check("midrun_strobe", gen_ena, 1);
    #1 rst = 1'b1;
    #1 check("async_rst_outputs", {gen_rst, gen_ena, busy, done, cmd_bus.cmd_ready}, 5'b10000);
    check("async_rst_pd", periods_done, 0);
    #1 rst = 1'b0;
    #1 check("gen_rst_after_release", {gen_rst, busy}, 2'b10);
    @(negedge clk);
    check("idle_after_async", cmd_bus.cmd_ready, 1);

    // cmd_valid held across a whole burst: only taken when cmd_ready is high,
    // and field changes while busy do not disturb the running burst.
    cmd_bus.cmd_valid = 1'b1; cmd_bus.cmd_div = 16'd0; cmd_bus.cmd_periods = 16'd1;
    @(posedge clk);
    #1 cmd_bus.cmd_div = 16'd7; cmd_bus.cmd_periods = 16'd3;
    @(negedge clk);
    check("held_init", {busy, gen_rst}, 2'b11);
    d_str = 0; d_k = 0; bad_ready = 0;
    for (int k = 1; k < 600; k++) begin
      @(negedge clk);
      if (gen_ena) d_str++;
      if (cmd_bus.cmd_ready) bad_ready++;
      if (done) begin d_k = k; break; end
    end
    check("held_strobes", d_str, 510);
    check("held_done_k", d_k, 511);
    check("held_ready_while_busy", bad_ready, 0);
    check("held_pd", periods_done, 1);
    @(negedge clk);
    check("held_ready_after_done", cmd_bus.cmd_ready, 1);
    @(negedge clk);
    check("held_reaccept_init", {busy, gen_rst, cmd_bus.cmd_ready}, 3'b110);
    check("held_reaccept_pd", periods_done, 0);

    // abort during INIT goes back through CLEAR without done.
    abort = 1'b1; cmd_bus.cmd_valid = 1'b0;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("init_abort_clear", {gen_rst, busy, done, cmd_bus.cmd_ready}, 4'b1000);
    @(negedge clk);
    check("init_abort_idle", {gen_rst, busy, done, cmd_bus.cmd_ready}, 4'b0001);

    // abort while idle is ignored.
    abort = 1'b1;
    @(negedge clk);
    check("idle_abort_ignored", {gen_rst, busy, cmd_bus.cmd_ready}, 3'b001);
    abort = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

endmodule
